// File: rtl/pipe_pkg.sv
// Shared definitions for the flow-controlled pipeline stage registers:
// occupancy state encoding, per-stage bundle widths and the NOP control word.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam int ID_EX_CTRL_W  = 8;
   localparam int ID_EX_DATA_W  = 111;
   localparam int EX_MEM_CTRL_W = 4;
   localparam int EX_MEM_DATA_W = 69;
   localparam int MEM_WB_CTRL_W = 2;
   localparam int MEM_WB_DATA_W = 69;

   // No register write, no memory access.
   localparam logic [ID_EX_CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+payload register. Load wins over clear; clear drops only the
// valid bit so the payload keeps its last value.
module pipe_skid_slot #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= din;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer
// (registered ready_o), flush with bubble insertion and async reset.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                CTRL_W      = ID_EX_CTRL_W,
   parameter int                DATA_W      = ID_EX_DATA_W,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        occ_o
);

   localparam int PW = CTRL_W + DATA_W;

   state_t state_reg, state_next;

   logic          main_load, main_clear, main_sel_skid;
   logic          skid_load, skid_clear;
   logic          main_valid, skid_valid;
   logic [PW-1:0] in_word, main_din, main_q, skid_q;
   logic          accept, release_w;

   assign in_word   = {ctrl_i, data_i};
   assign accept    = valid_i & ready_o;
   assign release_w = main_valid & ready_i;
   assign main_din  = main_sel_skid ? skid_q : in_word;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_reg <= ST_EMPTY;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next    = state_reg;
      main_load     = 1'b0;
      main_clear    = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      if (flush_i) begin
         // Any release this cycle has already been seen downstream.
         state_next = ST_EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (accept) begin
                  main_load  = 1'b1;
                  state_next = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && release_w) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load  = 1'b1;
                  state_next = ST_TWO;
               end else if (release_w) begin
                  main_clear = 1'b1;
                  state_next = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (release_w) begin
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
                  skid_clear    = 1'b1;
                  state_next    = ST_ONE;
               end
            end
            default: begin
               state_next = ST_EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   pipe_skid_slot #(.W(PW)) u_main (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load    (main_load),
      .clear   (main_clear),
      .din     (main_din),
      .valid   (main_valid),
      .q       (main_q)
   );

   pipe_skid_slot #(.W(PW)) u_skid (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load    (skid_load),
      .clear   (skid_clear),
      .din     (in_word),
      .valid   (skid_valid),
      .q       (skid_q)
   );

   assign ready_o = ~skid_valid;
   assign valid_o = main_valid;
   assign ctrl_o  = main_valid ? main_q[PW-1:DATA_W] : BUBBLE_CTRL;
   assign data_o  = main_q[DATA_W-1:0];
   assign occ_o   = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized checks of pipe_skid_stage against hand-computed
// values and a queue reference model.
module tb_pipe_skid_stage;

   localparam int          CW  = 8;
   localparam int          DW  = 111;
   localparam logic [CW-1:0] BUB = 8'hE1;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          valid_i, ready_o, flush_i, valid_o, ready_i;
   logic [CW-1:0] ctrl_i, ctrl_o;
   logic [DW-1:0] data_i, data_o;
   logic [1:0]    occ_o;

   int checks = 0;
   int errors = 0;

   pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(BUB)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .ctrl_i  (ctrl_i),
      .data_i  (data_i),
      .flush_i (flush_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .ctrl_o  (ctrl_o),
      .data_o  (data_o),
      .occ_o   (occ_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
      ctrl_i = '0; data_i = '0;
      tick(); tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
      checks++; if (ctrl_o !== BUB) begin errors++; $display("FAIL reset_ctrl got %h exp %h", ctrl_o, BUB); end
      checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
      checks++; if (occ_o !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occ_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
      rst_n_i = 1'b1;
      tick();
      $display("reset done");
   endtask

   task automatic test_stream();
      ready_i = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         valid_i = 1'b1; ctrl_i = CW'(8'h10 + i); data_i = DW'(i);
         tick();
         checks++; if (data_o !== DW'(i)) begin errors++; $display("FAIL stream_data got %h exp %h", data_o, DW'(i)); end
         checks++; if (ctrl_o !== CW'(8'h10 + i)) begin errors++; $display("FAIL stream_ctrl got %h exp %h", ctrl_o, CW'(8'h10 + i)); end
         checks++; if (valid_o !== 1'b1 || occ_o !== 2'd1 || ready_o !== 1'b1) begin
            errors++; $display("FAIL stream_flags got v%b o%0d r%b exp v1 o1 r1", valid_o, occ_o, ready_o); end
         $display("stream item %0d data_o %h", i, data_o);
      end
      valid_i = 1'b0;
      tick();
      checks++; if (valid_o !== 1'b0 || occ_o !== 2'd0 || ctrl_o !== BUB) begin
         errors++; $display("FAIL stream_drain got v%b o%0d c%h exp v0 o0 c%h", valid_o, occ_o, ctrl_o, BUB); end
   endtask

   task automatic test_fill_drain();
      ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 8'h0A; data_i = DW'(8'h0A);
      tick();
      checks++; if (occ_o !== 2'd1 || ready_o !== 1'b1 || data_o !== DW'(8'h0A)) begin
         errors++; $display("FAIL fill_first got o%0d r%b d%h exp o1 r1 d0a", occ_o, ready_o, data_o); end
      ctrl_i = 8'h0B; data_i = DW'(8'h0B);
      tick();
      checks++; if (occ_o !== 2'd2 || ready_o !== 1'b0 || data_o !== DW'(8'h0A)) begin
         errors++; $display("FAIL fill_second got o%0d r%b d%h exp o2 r0 d0a", occ_o, ready_o, data_o); end
      valid_i = 1'b0; ready_i = 1'b1;
      tick();
      checks++; if (data_o !== DW'(8'h0B) || ctrl_o !== 8'h0B || occ_o !== 2'd1 || ready_o !== 1'b1) begin
         errors++; $display("FAIL drain_b got d%h c%h o%0d r%b exp d0b c0b o1 r1", data_o, ctrl_o, occ_o, ready_o); end
      tick();
      checks++; if (valid_o !== 1'b0 || occ_o !== 2'd0) begin
         errors++; $display("FAIL drain_empty got v%b o%0d exp v0 o0", valid_o, occ_o); end
      $display("fill/drain done");
   endtask

   task automatic test_flush();
      ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 8'h01; data_i = DW'(8'h01);
      tick();
      ctrl_i = 8'h02; data_i = DW'(8'h02);
      tick();
      checks++; if (occ_o !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d exp 2", occ_o); end
      flush_i = 1'b1; ctrl_i = 8'h0C; data_i = DW'(8'h0C);
      tick();
      checks++; if (valid_o !== 1'b0 || ctrl_o !== BUB || occ_o !== 2'd0 || ready_o !== 1'b1) begin
         errors++; $display("FAIL flush_two got v%b c%h o%0d r%b exp v0 c%h o0 r1", valid_o, ctrl_o, occ_o, ready_o, BUB); end
      checks++; if (data_o !== DW'(8'h01)) begin errors++; $display("FAIL flush_data_hold got %h exp 01", data_o); end
      // Flush beats an accept while empty.
      ctrl_i = 8'h0D; data_i = DW'(8'h0D);
      tick();
      checks++; if (valid_o !== 1'b0 || occ_o !== 2'd0 || data_o !== DW'(8'h01)) begin
         errors++; $display("FAIL flush_accept got v%b o%0d d%h exp v0 o0 d01", valid_o, occ_o, data_o); end
      flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_emit got %b exp 0", valid_o); end
      $display("flush done");
   endtask

   task automatic test_stall();
      int bad = 0;
      ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 8'h5A; data_i = DW'(8'h77);
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ctrl_o !== 8'h5A || data_o !== DW'(8'h77) || valid_o !== 1'b1 || occ_o !== 2'd1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles exp 0", bad); end
      ready_i = 1'b1;
      tick();
      checks++; if (valid_o !== 1'b0 || occ_o !== 2'd0) begin
         errors++; $display("FAIL stall_release got v%b o%0d exp v0 o0", valid_o, occ_o); end
      $display("stall done");
   endtask

   task automatic test_async_reset();
      ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 8'h31; data_i = DW'(8'h31);
      tick();
      ctrl_i = 8'h32; data_i = DW'(8'h32);
      tick();
      valid_i = 1'b0;
      #2 rst_n_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0 || ctrl_o !== BUB || data_o !== '0 || occ_o !== 2'd0 || ready_o !== 1'b1) begin
         errors++; $display("FAIL async_reset got v%b c%h d%h o%0d r%b exp v0 c%h d0 o0 r1", valid_o, ctrl_o, data_o, occ_o, ready_o, BUB); end
      tick();
      rst_n_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; ctrl_i = 8'h41; data_i = DW'(8'h41);
      tick();
      checks++; if (valid_o !== 1'b1 || data_o !== DW'(8'h41) || occ_o !== 2'd1) begin
         errors++; $display("FAIL post_reset_accept got v%b d%h o%0d exp v1 d41 o1", valid_o, data_o, occ_o); end
      valid_i = 1'b0;
      tick();
      $display("async reset done");
   endtask

   task automatic test_random();
      logic [CW+DW-1:0] mq[$];
      logic [127:0]     r;
      logic             exp_ready, exp_valid, acc, rel;
      int               delivered = 0;
      valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         exp_ready = (mq.size() < 2);
         exp_valid = (mq.size() > 0);
         checks++;
         if (ready_o !== exp_ready || valid_o !== exp_valid || occ_o !== 2'(mq.size())) begin
            errors++; $display("FAIL rand_flags cyc %0d got v%b r%b o%0d exp v%b r%b o%0d",
                               cyc, valid_o, ready_o, occ_o, exp_valid, exp_ready, mq.size());
         end
         checks++;
         if (exp_valid) begin
            if ({ctrl_o, data_o} !== mq[0]) begin
               errors++; $display("FAIL rand_head cyc %0d got %h exp %h", cyc, {ctrl_o, data_o}, mq[0]);
            end
         end else if (ctrl_o !== BUB) begin
            errors++; $display("FAIL rand_bubble cyc %0d got %h exp %h", cyc, ctrl_o, BUB);
         end
         if (!(valid_i && !exp_ready)) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            valid_i = ($urandom_range(0, 3) != 0);
            ctrl_i  = r[127:120];
            data_i  = r[DW-1:0];
         end
         ready_i = ($urandom_range(0, 2) != 0);
         flush_i = ($urandom_range(0, 15) == 0);
         acc = valid_i & exp_ready;
         rel = exp_valid & ready_i;
         if (rel) begin
            void'(mq.pop_front());
            delivered++;
         end
         if (flush_i) mq.delete();
         else if (acc) mq.push_back({ctrl_i, data_i});
         tick();
      end
      valid_i = 1'b0; flush_i = 1'b0;
      $display("random done, %0d entries delivered", delivered);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill_drain();
      test_flush();
      test_stall();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
